// File: rtl/regfile_mp_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared constants, types and helpers for the multi-port register file.
//   XZR_IDX        : architectural index of the hard-wired zero register.
//   DEF_WIDTH/...  : default geometry of the register file.
//   reg_idx_t      : architectural register index (wide enough for XZR_IDX).
//   word_t         : architectural data word.
//   idx_live()     : true when an index addresses a real, writable register.
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int XZR_IDX   = 31;
    localparam int DEF_WIDTH = 64;
    localparam int DEF_DEPTH = 32;
    localparam int DEF_NREAD = 2;

    typedef logic [$clog2(XZR_IDX + 1)-1:0] reg_idx_t;
    typedef logic [DEF_WIDTH-1:0]           word_t;

    // An index is "live" when it maps onto storage: inside the array and not
    // the zero register. The same predicate masks writes and forces reads to
    // zero, which keeps the write mask and the bypass consistent.
    function automatic logic idx_live(input int unsigned idx,
                                      input int unsigned depth,
                                      input logic        zero_reg);
        return (idx < depth) && !(zero_reg && (idx == depth - 1));
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// ---------------------------------------------------------------------------
// regfile_mp_if
// Bus bundle between the decode stage (master) and the register file (slave).
//   wr_en/wr_addr/wr_data : single write port.
//   rd_en                 : per-port read request, NREAD bits.
//   rd_addr               : packed read indices, port p at [p*AW +: AW].
//   rd_data               : packed read data, port p at [p*WIDTH +: WIDTH].
//   rd_valid              : per-port data-valid flag.
// ---------------------------------------------------------------------------
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int NREAD = DEF_NREAD
) ();

    localparam int AW = $clog2(DEPTH);

    logic                   wr_en;
    logic [AW-1:0]          wr_addr;
    logic [WIDTH-1:0]       wr_data;
    logic [NREAD-1:0]       rd_en;
    logic [NREAD*AW-1:0]    rd_addr;
    logic [NREAD*WIDTH-1:0] rd_data;
    logic [NREAD-1:0]       rd_valid;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_data, rd_valid
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output rd_data, rd_valid
    );

endinterface

// File: rtl/regfile_mp_read_port.sv
// ---------------------------------------------------------------------------
// rf_read_port
// One read port of the register file: DEPTH:1 select, zero / out-of-range
// forcing, write-first bypass and an optional output register.
//   clk, reset          : clock, synchronous active-high reset.
//   mem                 : flattened storage from the top level.
//   byp_en/addr/data    : already-masked write, forwarded in its own cycle.
//   rd_en, rd_addr      : read request and index for this port.
//   rd_data, rd_valid   : read result (combinational or registered).
// ---------------------------------------------------------------------------
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ZERO_REG = 1,
    parameter int REG_OUT  = 0,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DEPTH-1:0][WIDTH-1:0] mem,
    input  logic                        byp_en,
    input  logic [AW-1:0]               byp_addr,
    input  logic [WIDTH-1:0]            byp_data,
    input  logic                        rd_en,
    input  logic [AW-1:0]               rd_addr,
    output logic [WIDTH-1:0]            rd_data,
    output logic                        rd_valid
);

    // ---- stage p0: combinational read value --------------------------------
    logic [WIDTH-1:0] sel_p0;
    logic             live_p0;
    logic             hit_p0;
    logic [WIDTH-1:0] val_p0;

    // Explicit decode instead of mem[rd_addr] so indices >= DEPTH simply
    // match nothing (non-power-of-two depths).
    always_comb begin
        sel_p0 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr == AW'(i)) begin
                sel_p0 = mem[i];
            end
        end
    end

    assign live_p0 = idx_live(32'(rd_addr), DEPTH, ZERO_REG != 0);
    assign hit_p0  = byp_en && (byp_addr == rd_addr);

    // Zero register and out-of-range win over the bypass; reset forces zero.
    always_comb begin
        val_p0 = sel_p0;
        if (reset || !live_p0) begin
            val_p0 = '0;
        end else if (hit_p0) begin
            val_p0 = byp_data;
        end
    end

    // ---- stage p1: optional output register --------------------------------
    logic [WIDTH-1:0] data_p1;
    logic             vld_p1;

    // Data only loads on a request so an idle port keeps its last result.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= rd_en;
            if (rd_en) begin
                data_p1 <= val_p0;
            end
        end
    end

    // The stage-p1 flops are dead logic in combinational mode and get trimmed.
    assign rd_data  = (REG_OUT != 0) ? data_p1 : val_p0;
    assign rd_valid = (REG_OUT != 0) ? vld_p1  : rd_en;

endmodule

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
// Parametrised multi-port register file for the pipelined CPU datapath.
// One synchronous write port, NREAD independent read ports, write-first
// bypass, optional hard-wired zero register (index DEPTH-1) and optional
// registered read stage.
//   clk   : clock, rising edge.
//   reset : synchronous active-high reset; clears storage and read registers.
//   bus   : regfile_mp_if slave (write port, read requests, read results).
// ---------------------------------------------------------------------------
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NREAD    = DEF_NREAD,
    parameter int ZERO_REG = 1,
    parameter int REG_OUT  = 0
) (
    input  logic         clk,
    input  logic         reset,
    regfile_mp_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic                        wr_ok;
    logic [NREAD-1:0][WIDTH-1:0] rd_data_w;
    logic [NREAD-1:0]            rd_valid_w;

    // A write that is masked (zero register, out of range, or under reset)
    // is dropped here, so it neither updates storage nor feeds the bypass.
    assign wr_ok = bus.wr_en && !reset
                   && idx_live(32'(bus.wr_addr), DEPTH, ZERO_REG != 0);

    // ---- storage -----------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            mem <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_ok && (bus.wr_addr == AW'(i))) begin
                    mem[i] <= bus.wr_data;
                end
            end
        end
    end

    // ---- read ports --------------------------------------------------------
    for (genvar p = 0; p < NREAD; p++) begin : g_port
        rf_read_port #(
            .WIDTH    (WIDTH),
            .DEPTH    (DEPTH),
            .ZERO_REG (ZERO_REG),
            .REG_OUT  (REG_OUT),
            .AW       (AW)
        ) u_port (
            .clk      (clk),
            .reset    (reset),
            .mem      (mem),
            .byp_en   (wr_ok),
            .byp_addr (bus.wr_addr),
            .byp_data (bus.wr_data),
            .rd_en    (bus.rd_en[p]),
            .rd_addr  (bus.rd_addr[p*AW +: AW]),
            .rd_data  (rd_data_w[p]),
            .rd_valid (rd_valid_w[p])
        );
    end

    assign bus.rd_data  = rd_data_w;
    assign bus.rd_valid = rd_valid_w;

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp
// Four register-file configurations share one stimulus stream:
//   c0: DEPTH=32 NREAD=2 ZERO_REG=1 REG_OUT=0
//   c1: DEPTH=32 NREAD=2 ZERO_REG=1 REG_OUT=1
//   c2: DEPTH=16 NREAD=3 ZERO_REG=0 REG_OUT=0
//   c3: DEPTH=20 NREAD=1 ZERO_REG=1 REG_OUT=1
// ---------------------------------------------------------------------------
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int NCFG = 4;
    localparam int DEP   [NCFG] = '{32, 32, 16, 20};
    localparam int NR    [NCFG] = '{2, 2, 3, 1};
    localparam int ZR    [NCFG] = '{1, 1, 0, 1};
    localparam int RO    [NCFG] = '{0, 1, 0, 1};
    localparam int AMASK [NCFG] = '{31, 31, 15, 31};

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    reg_idx_t   wr_addr;
    word_t      wr_data;
    logic [2:0] rd_en;
    reg_idx_t   ra [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_mp_if #(.WIDTH(64), .DEPTH(32), .NREAD(2)) if0 ();
    regfile_mp_if #(.WIDTH(64), .DEPTH(32), .NREAD(2)) if1 ();
    regfile_mp_if #(.WIDTH(64), .DEPTH(16), .NREAD(3)) if2 ();
    regfile_mp_if #(.WIDTH(64), .DEPTH(20), .NREAD(1)) if3 ();

    assign if0.wr_en = wr_en;  assign if0.wr_addr = wr_addr;      assign if0.wr_data = wr_data;
    assign if0.rd_en = rd_en[1:0];  assign if0.rd_addr = {ra[1], ra[0]};
    assign if1.wr_en = wr_en;  assign if1.wr_addr = wr_addr;      assign if1.wr_data = wr_data;
    assign if1.rd_en = rd_en[1:0];  assign if1.rd_addr = {ra[1], ra[0]};
    assign if2.wr_en = wr_en;  assign if2.wr_addr = wr_addr[3:0]; assign if2.wr_data = wr_data;
    assign if2.rd_en = rd_en;  assign if2.rd_addr = {ra[2][3:0], ra[1][3:0], ra[0][3:0]};
    assign if3.wr_en = wr_en;  assign if3.wr_addr = wr_addr;      assign if3.wr_data = wr_data;
    assign if3.rd_en = rd_en[0];  assign if3.rd_addr = ra[0];

    regfile_mp #(.WIDTH(64), .DEPTH(32), .NREAD(2), .ZERO_REG(1), .REG_OUT(0))
        u0 (.clk(clk), .reset(reset), .bus(if0));
    regfile_mp #(.WIDTH(64), .DEPTH(32), .NREAD(2), .ZERO_REG(1), .REG_OUT(1))
        u1 (.clk(clk), .reset(reset), .bus(if1));
    regfile_mp #(.WIDTH(64), .DEPTH(16), .NREAD(3), .ZERO_REG(0), .REG_OUT(0))
        u2 (.clk(clk), .reset(reset), .bus(if2));
    regfile_mp #(.WIDTH(64), .DEPTH(20), .NREAD(1), .ZERO_REG(1), .REG_OUT(1))
        u3 (.clk(clk), .reset(reset), .bus(if3));

    // Observed outputs gathered per configuration / port.
    word_t obs_d [NCFG][3];
    logic  obs_v [NCFG][3];
    assign obs_d[0][0] = if0.rd_data[63:0];    assign obs_v[0][0] = if0.rd_valid[0];
    assign obs_d[0][1] = if0.rd_data[127:64];  assign obs_v[0][1] = if0.rd_valid[1];
    assign obs_d[1][0] = if1.rd_data[63:0];    assign obs_v[1][0] = if1.rd_valid[0];
    assign obs_d[1][1] = if1.rd_data[127:64];  assign obs_v[1][1] = if1.rd_valid[1];
    assign obs_d[2][0] = if2.rd_data[63:0];    assign obs_v[2][0] = if2.rd_valid[0];
    assign obs_d[2][1] = if2.rd_data[127:64];  assign obs_v[2][1] = if2.rd_valid[1];
    assign obs_d[2][2] = if2.rd_data[191:128]; assign obs_v[2][2] = if2.rd_valid[2];
    assign obs_d[3][0] = if3.rd_data[63:0];    assign obs_v[3][0] = if3.rd_valid[0];

    // Reference model: architectural register contents and the value each
    // registered port is expected to show after the last edge.
    word_t mdl   [NCFG][32];
    word_t exp_q [NCFG][3];
    logic  exp_v [NCFG][3];

    function automatic bit writable(int c, int unsigned a);
        return (a < DEP[c]) && !(ZR[c] != 0 && a == DEP[c] - 1);
    endfunction

    function automatic word_t model_read(int c, int p);
        int unsigned a, wa;
        a  = 32'(ra[p])   & AMASK[c];
        wa = 32'(wr_addr) & AMASK[c];
        if (reset) return '0;
        if (ZR[c] != 0 && a == DEP[c] - 1) return '0;
        if (a >= DEP[c]) return '0;
        if (wr_en && wa == a && writable(c, wa)) return wr_data;
        return mdl[c][a];
    endfunction

    // Advance one clock (inputs already driven) and update the model.
    task automatic tick();
        word_t rv [NCFG][3];
        int unsigned wa;
        for (int c = 0; c < NCFG; c++)
            for (int p = 0; p < 3; p++) rv[c][p] = model_read(c, p);
        @(posedge clk);
        for (int c = 0; c < NCFG; c++) begin
            wa = 32'(wr_addr) & AMASK[c];
            if (reset) begin
                for (int i = 0; i < 32; i++) mdl[c][i] = '0;
                for (int p = 0; p < 3; p++) begin exp_q[c][p] = '0; exp_v[c][p] = 1'b0; end
            end else begin
                if (wr_en && writable(c, wa)) mdl[c][wa] = wr_data;
                for (int p = 0; p < NR[c]; p++) begin
                    exp_v[c][p] = rd_en[p];
                    if (rd_en[p]) exp_q[c][p] = rv[c][p];
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_en = 3'b111; ra[0] = 5'd0; ra[1] = 5'd1; ra[2] = 5'd2;
        #1;
        for (int p = 0; p < 2; p++) begin
            checks++;
            if (obs_d[0][p] !== 64'h0) begin
                failures++; $display("FAIL reset_comb_data p%0d: got %h want %h", p, obs_d[0][p], 64'h0);
            end
        end
        tick();
        for (int p = 0; p < 2; p++) begin
            checks++;
            if (obs_v[1][p] !== 1'b0 || obs_d[1][p] !== 64'h0) begin
                failures++; $display("FAIL reset_reg p%0d: got v=%b d=%h want v=0 d=0", p, obs_v[1][p], obs_d[1][p]);
            end
        end
        reset = 1'b0;
        #1;
        for (int p = 0; p < 2; p++) begin
            checks++;
            if (obs_d[0][p] !== 64'h0) begin
                failures++; $display("FAIL post_reset_comb p%0d: got %h want %h", p, obs_d[0][p], 64'h0);
            end
        end
        tick();
        for (int p = 0; p < 2; p++) begin
            checks++;
            if (obs_v[1][p] !== 1'b1 || obs_d[1][p] !== 64'h0) begin
                failures++; $display("FAIL post_reset_reg p%0d: got v=%b d=%h want v=1 d=0", p, obs_v[1][p], obs_d[1][p]);
            end
        end
    endtask

    task automatic test_write_readback();
        rd_en = 3'b000; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEAD_BEEF_0123_4567;
        tick();
        wr_en = 1'b0; rd_en = 3'b011; ra[0] = 5'd5; ra[1] = 5'd5;
        #1;
        for (int p = 0; p < 2; p++) begin
            checks++;
            if (obs_d[0][p] !== 64'hDEAD_BEEF_0123_4567) begin
                failures++; $display("FAIL readback_comb p%0d: got %h want %h", p, obs_d[0][p], 64'hDEAD_BEEF_0123_4567);
            end
        end
        tick();
        for (int p = 0; p < 2; p++) begin
            checks++;
            if (obs_v[1][p] !== 1'b1 || obs_d[1][p] !== 64'hDEAD_BEEF_0123_4567) begin
                failures++; $display("FAIL readback_reg p%0d: got v=%b d=%h want v=1 d=%h", p, obs_v[1][p], obs_d[1][p], 64'hDEAD_BEEF_0123_4567);
            end
        end
        ra[0] = 5'd4;
        #1;
        checks++;
        if (obs_d[0][0] !== 64'h0) begin
            failures++; $display("FAIL x4_comb: got %h want %h", obs_d[0][0], 64'h0);
        end
        tick();
        checks++;
        if (obs_d[1][0] !== 64'h0) begin
            failures++; $display("FAIL x4_reg: got %h want %h", obs_d[1][0], 64'h0);
        end
    endtask

    task automatic test_bypass();
        rd_en = 3'b000; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h1111_2222_3333_4444;
        tick();
        wr_data = 64'hA5A5_A5A5_A5A5_A5A5; rd_en = 3'b001; ra[0] = 5'd7;
        #1;
        checks++;
        if (obs_d[0][0] !== 64'hA5A5_A5A5_A5A5_A5A5) begin
            failures++; $display("FAIL bypass_comb: got %h want %h", obs_d[0][0], 64'hA5A5_A5A5_A5A5_A5A5);
        end
        tick();
        checks++;
        if (obs_d[1][0] !== 64'hA5A5_A5A5_A5A5_A5A5) begin
            failures++; $display("FAIL bypass_reg: got %h want %h", obs_d[1][0], 64'hA5A5_A5A5_A5A5_A5A5);
        end
        wr_en = 1'b0;
    endtask

    task automatic test_zero_reg();
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
        rd_en = 3'b010; ra[1] = 5'd31;
        #1;
        checks++;
        if (obs_d[0][1] !== 64'h0) begin
            failures++; $display("FAIL xzr_bypass_comb: got %h want %h", obs_d[0][1], 64'h0);
        end
        tick();
        checks++;
        if (obs_d[1][1] !== 64'h0) begin
            failures++; $display("FAIL xzr_bypass_reg: got %h want %h", obs_d[1][1], 64'h0);
        end
        wr_en = 1'b0;
        #1;
        checks++;
        if (obs_d[0][1] !== 64'h0) begin
            failures++; $display("FAIL xzr_after_comb: got %h want %h", obs_d[0][1], 64'h0);
        end
        tick();
        checks++;
        if (obs_d[1][1] !== 64'h0) begin
            failures++; $display("FAIL xzr_after_reg: got %h want %h", obs_d[1][1], 64'h0);
        end
    endtask

    task automatic test_reset_mid();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h1234;
        rd_en = 3'b011; ra[0] = 5'd3; ra[1] = 5'd3;
        tick();
        wr_en = 1'b0;
        tick();
        for (int p = 0; p < 2; p++) begin
            checks++;
            if (obs_v[1][p] !== 1'b1 || obs_d[1][p] !== 64'h1234) begin
                failures++; $display("FAIL stream_reg p%0d: got v=%b d=%h want v=1 d=%h", p, obs_v[1][p], obs_d[1][p], 64'h1234);
            end
        end
        reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h9999;
        tick();
        for (int p = 0; p < 2; p++) begin
            checks++;
            if (obs_v[1][p] !== 1'b0 || obs_d[1][p] !== 64'h0) begin
                failures++; $display("FAIL mid_reset_reg p%0d: got v=%b d=%h want v=0 d=0", p, obs_v[1][p], obs_d[1][p]);
            end
        end
        reset = 1'b0; wr_en = 1'b0;
        #1;
        checks++;
        if (obs_d[0][0] !== 64'h0) begin
            failures++; $display("FAIL lost_write_comb: got %h want %h", obs_d[0][0], 64'h0);
        end
        tick();
        for (int p = 0; p < 2; p++) begin
            checks++;
            if (obs_v[1][p] !== 1'b1 || obs_d[1][p] !== 64'h0) begin
                failures++; $display("FAIL lost_write_reg p%0d: got v=%b d=%h want v=1 d=0", p, obs_v[1][p], obs_d[1][p]);
            end
        end
    endtask

    task automatic test_random();
        word_t want;
        for (int n = 0; n < 1000; n++) begin
            reset   = ($urandom_range(0, 63) == 0);
            wr_en   = $urandom_range(0, 1);
            wr_addr = reg_idx_t'($urandom_range(0, 31));
            wr_data = {$urandom, $urandom};
            rd_en   = 3'($urandom_range(0, 7));
            for (int p = 0; p < 3; p++)
                ra[p] = ($urandom_range(0, 3) == 0) ? wr_addr : reg_idx_t'($urandom_range(0, 31));
            #1;
            for (int c = 0; c < NCFG; c += 2) begin
                for (int p = 0; p < NR[c]; p++) begin
                    want = model_read(c, p);
                    checks++;
                    if (obs_d[c][p] !== want || obs_v[c][p] !== rd_en[p]) begin
                        failures++;
                        $display("FAIL rand_comb c%0d p%0d cyc%0d: got v=%b d=%h want v=%b d=%h",
                                 c, p, n, obs_v[c][p], obs_d[c][p], rd_en[p], want);
                    end
                end
            end
            tick();
            for (int c = 1; c < NCFG; c += 2) begin
                for (int p = 0; p < NR[c]; p++) begin
                    checks++;
                    if (obs_d[c][p] !== exp_q[c][p] || obs_v[c][p] !== exp_v[c][p]) begin
                        failures++;
                        $display("FAIL rand_reg c%0d p%0d cyc%0d: got v=%b d=%h want v=%b d=%h",
                                 c, p, n, obs_v[c][p], obs_d[c][p], exp_v[c][p], exp_q[c][p]);
                    end
                end
            end
        end
        reset = 1'b0; wr_en = 1'b0; rd_en = 3'b000;
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = '0;
        for (int p = 0; p < 3; p++) ra[p] = '0;
        @(negedge clk);
        test_reset();
        test_write_readback();
        test_bypass();
        test_zero_reg();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
